stream_mux_rr: RTL and testbench

Parametrised N-channel streaming multiplexer with valid/ready handshakes, round-robin arbitration and one registered output stage. It generalises the 4-bit 2:1/4:1 selection muxes into a sequential block. Source selection comes from the internal arbiter, not an external `sel` input. It sits between several producers and one consumer. It reports which channel each output word came from.

---
 rtl/stream_mux_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 73 +++++++
 rtl/stream_mux_rr.sv | 64 ++++++
 tb/tb_stream_mux_rr.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
package stream_mux_pkg;

  localparam int unsigned N_CH_MAX = 16;

  // Next index with wrap to zero at n.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant over N_CH requesters plus the rotation pointer register.
// STREAM_MUX_RR_EN selects round-robin search; otherwise fixed lowest-index priority.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  localparam int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  req,
  input  logic             en,
  input  logic             advance,
  output logic [N_CH-1:0]  gnt,
  output logic [SEL_W-1:0] gnt_idx
);

  logic             found;
  logic [SEL_W-1:0] win_idx;

`ifdef STREAM_MUX_RR_EN
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] idx;

  // Last granted channel; reset makes channel 0 the first candidate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= SEL_W'(N_CH - 1);
    end else if (advance) begin
      ptr_q <= gnt_idx;
    end
  end

  // Search starts one past the last winner and wraps modulo N_CH.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    idx     = SEL_W'(next_idx(32'(ptr_q), N_CH));
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
      idx = SEL_W'(next_idx(32'(idx), N_CH));
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk, rst_n, advance};

  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!found && req[i]) begin
        found   = 1'b1;
        win_idx = SEL_W'(i);
      end
    end
  end
`endif

  // Grant only when the consumer side can take a word.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    if (en && found) begin
      gnt[win_idx] = 1'b1;
      gnt_idx      = win_idx;
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with one registered output stage.
// Arbitration mode is chosen by STREAM_MUX_RR_EN (round-robin) or fixed priority when undefined.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 4,
  localparam int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_CH-1:0][WIDTH-1:0]  in_data,
  input  logic [N_CH-1:0]             in_valid,
  output logic [N_CH-1:0]             in_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [SEL_W-1:0]            out_sel,
  output logic                        out_valid,
  input  logic                        out_ready
);

  if (N_CH < 2 || N_CH > N_CH_MAX || WIDTH < 1) begin : g_bad_cfg
    $error("stream_mux_rr: unsupported N_CH/WIDTH");
  end

  logic             load_en;
  logic             accept;
  logic [N_CH-1:0]  gnt;
  logic [SEL_W-1:0] gnt_idx;

  // Output slot is free or being drained this cycle; reset blocks all grants.
  assign load_en  = rst_n && (!out_valid || out_ready);
  assign accept   = |gnt;
  assign in_ready = gnt;

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (in_valid),
    .en      (load_en),
    .advance (accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Only the granted lane is ever captured, so X on other lanes cannot propagate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
    end else if (load_en) begin
      if (accept) begin
        out_data  <= in_data[gnt_idx];
        out_sel   <= gnt_idx;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr (N_CH=4, WIDTH=4); expectations follow STREAM_MUX_RR_EN.
module tb_stream_mux_rr;

  logic            clk;
  logic            rst_n;
  logic [3:0][3:0] in_data;
  logic [3:0]      in_valid;
  logic [3:0]      in_ready;
  logic [3:0]      out_data;
  logic [1:0]      out_sel;
  logic            out_valid;
  logic            out_ready;

  int total;
  int bad;

  // Reference state: last grant and output-occupied flag.
  int   m_ptr;
  bit   m_ov;
  logic [3:0] exp_d[$];
  logic [1:0] exp_s[$];

  stream_mux_rr #(.N_CH(4), .WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] v);
`ifdef STREAM_MUX_RR_EN
    for (int k = 1; k <= 4; k++) begin
      if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
`else
    for (int i = 0; i < 4; i++) begin
      if (v[i]) return i;
    end
`endif
    return -1;
  endfunction

  // One clock: check in_ready, retire a consumed word, push an accepted one, check out_valid.
  task automatic step();
    int         g;
    bit         load;
    logic [3:0] exp_rdy;
    logic [3:0] d;
    logic [1:0] s;
    #1;
    load    = (rst_n === 1'b1) && (!m_ov || out_ready === 1'b1);
    g       = load ? pick(in_valid) : -1;
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
    total++;
    if (in_ready !== exp_rdy) begin
      bad++;
      $display("FAIL in_ready got=%b want=%b t=%0t", in_ready, exp_rdy, $time);
    end
    if (m_ov && out_ready === 1'b1) begin
      total++;
      if (exp_d.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_underflow got=%h want=none t=%0t", out_data, $time);
      end else begin
        d = exp_d.pop_front();
        s = exp_s.pop_front();
        if (out_data !== d || out_sel !== s) begin
          bad++;
          $display("FAIL consumed_word got=%h/%0d want=%h/%0d t=%0t", out_data, out_sel, d, s, $time);
        end
      end
    end
    if (g >= 0) begin
      exp_d.push_back(in_data[g]);
      exp_s.push_back(2'(g));
      m_ptr = g;
      m_ov  = 1'b1;
    end else if (load) begin
      m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== m_ov) begin
      bad++;
      $display("FAIL out_valid got=%b want=%b t=%0t", out_valid, m_ov, $time);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    m_ptr     = 3;
    m_ov      = 1'b0;
    exp_d.delete();
    exp_s.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    in_data   = {4'hE, 4'h9, 4'h5, 4'h3};
    m_ptr     = 3;
    m_ov      = 1'b0;
    exp_d.delete();
    exp_s.delete();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0 || out_data !== 4'h0 || in_ready !== 4'b0000) begin
        bad++;
        $display("FAIL reset_state got=%b/%h/%b want=0/0/0000", out_valid, out_data, in_ready);
      end
    end
    rst_n = 1'b1;
    step();
    total++;
    if (out_sel !== 2'd0 || out_data !== 4'h3) begin
      bad++;
      $display("FAIL reset_first_grant got=%0d/%h want=0/3", out_sel, out_data);
    end
  endtask

  task automatic test_rotation();
    logic [1:0] es[5];
    logic [3:0] ed[5];
`ifdef STREAM_MUX_RR_EN
    es = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    ed = '{4'h3, 4'h5, 4'h9, 4'hE, 4'h3};
`else
    es = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    ed = '{4'h3, 4'h3, 4'h3, 4'h3, 4'h3};
`endif
    do_reset();
    in_data  = {4'hE, 4'h9, 4'h5, 4'h3};
    in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (out_sel !== es[i] || out_data !== ed[i]) begin
        bad++;
        $display("FAIL rotation[%0d] got=%0d/%h want=%0d/%h", i, out_sel, out_data, es[i], ed[i]);
      end
    end
  endtask

  task automatic test_sparse();
    logic [1:0] es[4];
`ifdef STREAM_MUX_RR_EN
    es = '{2'd1, 2'd3, 2'd1, 2'd3};
`else
    es = '{2'd1, 2'd1, 2'd1, 2'd1};
`endif
    do_reset();
    in_data  = {4'hE, 4'h9, 4'h5, 4'h3};
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (out_sel !== es[i]) begin
        bad++;
        $display("FAIL sparse[%0d] got=%0d want=%0d", i, out_sel, es[i]);
      end
    end
    in_valid = 4'b0001;
    step();
    total++;
    if (out_sel !== 2'd0 || out_data !== 4'h3) begin
      bad++;
      $display("FAIL sparse_ch0 got=%0d/%h want=0/3", out_sel, out_data);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_data  = {4'h3, 4'h7, 4'h1, 4'h2};
    in_valid = 4'b0100;
    step();
    in_valid  = 4'b1000;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (out_data !== 4'h7 || out_sel !== 2'd2 || in_ready !== 4'b0000) begin
        bad++;
        $display("FAIL stall[%0d] got=%h/%0d/%b want=7/2/0000", i, out_data, out_sel, in_ready);
      end
    end
    out_ready = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b1 || out_data !== 4'h3 || out_sel !== 2'd3) begin
      bad++;
      $display("FAIL refill got=%b/%h/%0d want=1/3/3", out_valid, out_data, out_sel);
    end
    in_valid = 4'b0000;
    step();
  endtask

  task automatic test_drain();
    do_reset();
    in_data  = {4'hE, 4'h9, 4'h5, 4'h3};
    in_valid = 4'b1111;
    step();
    in_valid = 4'b0000;
    step();
    total++;
    if (out_valid !== 1'b0 || out_data !== 4'h3 || out_sel !== 2'd0) begin
      bad++;
      $display("FAIL drain got=%b/%h/%0d want=0/3/0", out_valid, out_data, out_sel);
    end
    step();
    in_valid = 4'b1111;
    step();
    total++;
`ifdef STREAM_MUX_RR_EN
    if (out_sel !== 2'd1 || out_data !== 4'h5) begin
      bad++;
      $display("FAIL drain_resume got=%0d/%h want=1/5", out_sel, out_data);
    end
`else
    if (out_sel !== 2'd0 || out_data !== 4'h3) begin
      bad++;
      $display("FAIL drain_resume got=%0d/%h want=0/3", out_sel, out_data);
    end
`endif
  endtask

  task automatic test_x_isolation();
    do_reset();
    in_data  = {4'bxxxx, 4'h6, 4'bxxxx, 4'h4};
    in_valid = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ($isunknown(out_data)) begin
        bad++;
        $display("FAIL x_leak[%0d] got=%b want=known", i, out_data);
      end
    end
    in_valid = 4'b0000;
    step();
  endtask

`ifndef STREAM_MUX_RR_EN
  task automatic test_fixed_priority();
    do_reset();
    in_data  = {4'hE, 4'h9, 4'h5, 4'h3};
    in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (out_sel !== 2'd0) begin
        bad++;
        $display("FAIL fixed[%0d] got=%0d want=0", i, out_sel);
      end
    end
    in_valid = 4'b1110;
    step();
    total++;
    if (out_sel !== 2'd1 || out_data !== 4'h5) begin
      bad++;
      $display("FAIL fixed_drop0 got=%0d/%h want=1/5", out_sel, out_data);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_rotation();
    test_sparse();
    test_backpressure();
    test_drain();
    test_x_isolation();
`ifndef STREAM_MUX_RR_EN
    test_fixed_priority();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
